// File: rtl/ic_bram_arbiter.sv
// rtl/ic_bram_arbiter.sv - two-port (I/D) to one-port CPU bus arbiter with in-order response routing
module ic_bram_arbiter #(
  parameter int PRIORITY        = 0,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1,
  localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             i_req,
  input  logic             d_req,
  output logic             i_gnt,
  output logic             d_gnt,
  input  logic             i_wen,
  input  logic             d_wen,
  input  logic [3:0]       i_strb,
  input  logic [3:0]       d_strb,
  input  logic [31:0]      i_wdata,
  input  logic [31:0]      d_wdata,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      d_addr,
  output logic             i_recv,
  output logic             d_recv,
  input  logic             i_ack,
  input  logic             d_ack,
  output logic             i_error,
  output logic             d_error,
  output logic [31:0]      i_rdata,
  output logic [31:0]      d_rdata,
  output logic             s_req,
  input  logic             s_gnt,
  output logic             s_wen,
  output logic [3:0]       s_strb,
  output logic [31:0]      s_wdata,
  output logic [31:0]      s_addr,
  input  logic             s_recv,
  output logic             s_ack,
  input  logic             s_error,
  input  logic [31:0]      s_rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_orphan
);

  // Port IDs throughout: 0 = I, 1 = D.
  logic             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_grant_q, last_grant_d;
  logic             orphan_q, orphan_d;

  logic sel_req, sel_d, full, empty, head, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_req = i_req | d_req;
    if (i_req && d_req) sel_d = (PRIORITY != 0) ? 1'b1 : ~last_grant_q;
    else                sel_d = d_req;
  end

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  assign s_req   = sel_req & ~full;
  assign s_wen   = sel_d ? d_wen   : i_wen;
  assign s_strb  = sel_d ? d_strb  : i_strb;
  assign s_wdata = sel_d ? d_wdata : i_wdata;
  assign s_addr  = sel_d ? d_addr  : i_addr;
  assign i_gnt   = s_req & ~sel_d & s_gnt;
  assign d_gnt   = s_req &  sel_d & s_gnt;

  // With nothing tracked, responses are drained so the downstream never stalls.
  assign i_recv  = ~empty & ~head & s_recv;
  assign d_recv  = ~empty &  head & s_recv;
  assign s_ack   = empty ? s_recv : (head ? d_ack : i_ack);
  assign i_error = ~empty & ~head & s_error;
  assign d_error = ~empty &  head & s_error;
  assign i_rdata = (~empty & ~head) ? s_rdata : '0;
  assign d_rdata = (~empty &  head) ? s_rdata : '0;

  assign push = s_req & s_gnt;
  assign pop  = ~empty & s_recv & s_ack;

  always_comb begin
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    last_grant_d = push ? sel_d : last_grant_q;
    orphan_d     = orphan_q | (empty & s_recv);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      orphan_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      orphan_q     <= orphan_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) fifo_q[wr_ptr_q] <= sel_d;
  end

  assign outstanding = count_q;
  assign err_orphan  = orphan_q;

endmodule

// File: tb/tb_ic_bram_arbiter.sv
// tb/tb_ic_bram_arbiter.sv - self-checking bench for ic_bram_arbiter (round-robin and fixed-priority instances)
module tb_ic_bram_arbiter;
  localparam int MAXO = 2;

  logic g_clk = 1'b0, g_reset;
  logic i_req, d_req, i_wen, d_wen, i_ack, d_ack, s_gnt, s_recv, s_error;
  logic [3:0] i_strb, d_strb;
  logic [31:0] i_wdata, d_wdata, i_addr, d_addr, s_rdata;

  logic a_i_gnt, a_d_gnt, a_i_recv, a_d_recv, a_i_error, a_d_error, a_s_req, a_s_wen, a_s_ack, a_err_orphan;
  logic [3:0] a_s_strb;
  logic [31:0] a_i_rdata, a_d_rdata, a_s_wdata, a_s_addr;
  logic [1:0] a_outstanding;
  logic b_i_gnt, b_d_gnt, b_i_recv, b_d_recv, b_i_error, b_d_error, b_s_req, b_s_wen, b_s_ack, b_err_orphan;
  logic [3:0] b_s_strb;
  logic [31:0] b_i_rdata, b_d_rdata, b_s_wdata, b_s_addr;
  logic [1:0] b_outstanding;

  ic_bram_arbiter #(.PRIORITY(0), .MAX_OUTSTANDING(MAXO)) dut_rr (
    .g_clk(g_clk), .g_reset(g_reset), .i_req(i_req), .d_req(d_req), .i_gnt(a_i_gnt), .d_gnt(a_d_gnt),
    .i_wen(i_wen), .d_wen(d_wen), .i_strb(i_strb), .d_strb(d_strb), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_addr(i_addr), .d_addr(d_addr), .i_recv(a_i_recv), .d_recv(a_d_recv), .i_ack(i_ack), .d_ack(d_ack),
    .i_error(a_i_error), .d_error(a_d_error), .i_rdata(a_i_rdata), .d_rdata(a_d_rdata), .s_req(a_s_req),
    .s_gnt(s_gnt), .s_wen(a_s_wen), .s_strb(a_s_strb), .s_wdata(a_s_wdata), .s_addr(a_s_addr),
    .s_recv(s_recv), .s_ack(a_s_ack), .s_error(s_error), .s_rdata(s_rdata), .outstanding(a_outstanding),
    .err_orphan(a_err_orphan));

  ic_bram_arbiter #(.PRIORITY(1), .MAX_OUTSTANDING(MAXO)) dut_fp (
    .g_clk(g_clk), .g_reset(g_reset), .i_req(i_req), .d_req(d_req), .i_gnt(b_i_gnt), .d_gnt(b_d_gnt),
    .i_wen(i_wen), .d_wen(d_wen), .i_strb(i_strb), .d_strb(d_strb), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_addr(i_addr), .d_addr(d_addr), .i_recv(b_i_recv), .d_recv(b_d_recv), .i_ack(i_ack), .d_ack(d_ack),
    .i_error(b_i_error), .d_error(b_d_error), .i_rdata(b_i_rdata), .d_rdata(b_d_rdata), .s_req(b_s_req),
    .s_gnt(s_gnt), .s_wen(b_s_wen), .s_strb(b_s_strb), .s_wdata(b_s_wdata), .s_addr(b_s_addr),
    .s_recv(s_recv), .s_ack(b_s_ack), .s_error(s_error), .s_rdata(s_rdata), .outstanding(b_outstanding),
    .err_orphan(b_err_orphan));

  always #5 g_clk = ~g_clk;

  // Observed view of whichever instance the current test targets (0 = round-robin, 1 = fixed priority).
  bit msel;
  logic o_i_gnt, o_d_gnt, o_i_recv, o_d_recv, o_i_error, o_d_error, o_s_req, o_s_wen, o_s_ack, o_err_orphan;
  logic [3:0] o_s_strb;
  logic [31:0] o_i_rdata, o_d_rdata, o_s_wdata, o_s_addr;
  logic [1:0] o_outstanding;
  assign {o_i_gnt, o_d_gnt, o_i_recv, o_d_recv, o_i_error, o_d_error, o_s_req, o_s_wen, o_s_ack, o_err_orphan} = msel ?
    {b_i_gnt, b_d_gnt, b_i_recv, b_d_recv, b_i_error, b_d_error, b_s_req, b_s_wen, b_s_ack, b_err_orphan} :
    {a_i_gnt, a_d_gnt, a_i_recv, a_d_recv, a_i_error, a_d_error, a_s_req, a_s_wen, a_s_ack, a_err_orphan};
  assign {o_s_strb, o_i_rdata, o_d_rdata, o_s_wdata, o_s_addr, o_outstanding} = msel ?
    {b_s_strb, b_i_rdata, b_d_rdata, b_s_wdata, b_s_addr, b_outstanding} :
    {a_s_strb, a_i_rdata, a_d_rdata, a_s_wdata, a_s_addr, a_outstanding};

  int checks = 0, errors = 0;

  // Reference model: queue of port IDs in acceptance order, last winner, sticky orphan flag.
  bit mq[$];
  bit mlast = 1'b1, morph = 1'b0;
  bit e_sel, e_i_gnt, e_d_gnt, e_s_req, e_i_recv, e_d_recv, e_s_ack, e_i_error, e_d_error, e_s_wen, e_push, e_pop;
  logic [3:0] e_s_strb;
  logic [31:0] e_i_rdata, e_d_rdata, e_s_wdata, e_s_addr;
  logic [1:0] e_out;

  task automatic model_eval();
    bit full, any;
    full = (mq.size() == MAXO);
    any = i_req || d_req;
    if (i_req && d_req) e_sel = msel ? 1'b1 : !mlast;
    else e_sel = d_req;
    e_s_req = any && !full;
    e_i_gnt = e_s_req && s_gnt && !e_sel;
    e_d_gnt = e_s_req && s_gnt && e_sel;
    e_s_wen = e_sel ? d_wen : i_wen;
    e_s_strb = e_sel ? d_strb : i_strb;
    e_s_wdata = e_sel ? d_wdata : i_wdata;
    e_s_addr = e_sel ? d_addr : i_addr;
    e_i_recv = 0; e_d_recv = 0; e_i_error = 0; e_d_error = 0; e_i_rdata = 0; e_d_rdata = 0;
    if (mq.size() > 0) begin
      if (mq[0]) begin e_d_recv = s_recv; e_d_error = s_error; e_d_rdata = s_rdata; e_s_ack = d_ack; end
      else begin e_i_recv = s_recv; e_i_error = s_error; e_i_rdata = s_rdata; e_s_ack = i_ack; end
    end else e_s_ack = s_recv;
    e_out = 2'(mq.size());
    e_push = e_s_req && s_gnt;
    e_pop = (mq.size() > 0) && s_recv && e_s_ack;
  endtask

  task automatic model_commit();
    if (g_reset) begin mq.delete(); mlast = 1'b1; morph = 1'b0; end
    else begin
      if (mq.size() == 0 && s_recv) morph = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin mq.push_back(e_sel); mlast = e_sel; end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge g_clk);
    model_commit();
    @(negedge g_clk);
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; i_wen = 0; d_wen = 0; i_ack = 0; d_ack = 0; s_gnt = 0; s_recv = 0; s_error = 0;
    i_strb = 0; d_strb = 0; i_wdata = 0; d_wdata = 0; i_addr = 0; d_addr = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    idle(); g_reset = 1; tick(); g_reset = 0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      msel = 1'(s); do_reset(); #1;
      checks++; if ({o_i_gnt, o_d_gnt, o_i_recv, o_d_recv, o_s_req, o_s_ack} !== 6'b0) begin errors++; $display("FAIL reset_handshakes inst=%0d: got %b want 000000", s, {o_i_gnt, o_d_gnt, o_i_recv, o_d_recv, o_s_req, o_s_ack}); end
      checks++; if (o_outstanding !== 2'd0 || o_err_orphan !== 1'b0) begin errors++; $display("FAIL reset_state inst=%0d: outstanding=%0d orphan=%b want 0/0", s, o_outstanding, o_err_orphan); end
    end
  endtask

  task automatic test_single_port();
    msel = 0; do_reset();
    i_req = 1; i_addr = 32'h100; s_gnt = 1; #1;
    checks++; if (o_i_gnt !== 1'b1 || o_s_req !== 1'b1 || o_s_addr !== 32'h100) begin errors++; $display("FAIL single_grant: gnt=%b s_req=%b addr=%h want 1/1/00000100", o_i_gnt, o_s_req, o_s_addr); end
    checks++; if (o_outstanding !== 2'd0) begin errors++; $display("FAIL single_out0: got %0d want 0", o_outstanding); end
    tick();
    i_req = 0; s_recv = 1; s_rdata = 32'hDEADBEEF; i_ack = 1; #1;
    checks++; if (o_i_recv !== 1'b1 || o_i_rdata !== 32'hDEADBEEF || o_d_recv !== 1'b0) begin errors++; $display("FAIL single_resp: i_recv=%b rdata=%h d_recv=%b want 1/deadbeef/0", o_i_recv, o_i_rdata, o_d_recv); end
    checks++; if (o_outstanding !== 2'd1 || o_s_ack !== 1'b1) begin errors++; $display("FAIL single_out1: out=%0d s_ack=%b want 1/1", o_outstanding, o_s_ack); end
    tick(); idle(); #1;
    checks++; if (o_outstanding !== 2'd0 || o_i_recv !== 1'b0) begin errors++; $display("FAIL single_drain: out=%0d i_recv=%b want 0/0", o_outstanding, o_i_recv); end
  endtask

  task automatic test_rr_contention();
    bit want_i [4];
    want_i = '{1'b1, 1'b0, 1'b1, 1'b0};
    msel = 0; do_reset();
    i_addr = 32'h1000; d_addr = 32'h2000; s_gnt = 1; i_ack = 1; d_ack = 1;
    for (int k = 0; k < 5; k++) begin
      i_req = (k < 4); d_req = (k < 4); s_recv = (k > 0); s_rdata = 32'hA000 + k; #1;
      if (k < 4) begin
        checks++; if (o_i_gnt !== want_i[k] || o_d_gnt !== !want_i[k]) begin errors++; $display("FAIL rr_grant[%0d]: i=%b d=%b want i=%b", k, o_i_gnt, o_d_gnt, want_i[k]); end
        checks++; if (o_s_addr !== (want_i[k] ? 32'h1000 : 32'h2000)) begin errors++; $display("FAIL rr_addr[%0d]: got %h", k, o_s_addr); end
      end
      if (k > 0) begin
        checks++; if (o_i_recv !== want_i[k-1] || o_d_recv !== !want_i[k-1]) begin errors++; $display("FAIL rr_route[%0d]: i_recv=%b d_recv=%b want i=%b", k, o_i_recv, o_d_recv, want_i[k-1]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_priority();
    msel = 1; do_reset();
    s_gnt = 1; i_ack = 1; d_ack = 1;
    for (int k = 0; k < 4; k++) begin
      i_req = 1; d_req = (k < 3); s_recv = (k > 0); #1;
      checks++; if (o_d_gnt !== (k < 3) || o_i_gnt !== (k == 3)) begin errors++; $display("FAIL prio[%0d]: i_gnt=%b d_gnt=%b want i=%b d=%b", k, o_i_gnt, o_d_gnt, k == 3, k < 3); end
      tick();
    end
    idle(); s_recv = 1; i_ack = 1; tick(); idle(); #1;
    checks++; if (o_outstanding !== 2'd0) begin errors++; $display("FAIL prio_drain: got %0d want 0", o_outstanding); end
    msel = 0;
  endtask

  task automatic test_full();
    msel = 0; do_reset();
    d_req = 1; d_wen = 1; d_strb = 4'hF; s_gnt = 1;
    for (int k = 0; k < 2; k++) begin
      d_addr = 32'h300 + 4 * k; d_wdata = 32'h11 * (k + 1); #1;
      checks++; if (o_d_gnt !== 1'b1 || o_s_wen !== 1'b1 || o_s_wdata !== d_wdata) begin errors++; $display("FAIL full_wr[%0d]: gnt=%b wen=%b wdata=%h", k, o_d_gnt, o_s_wen, o_s_wdata); end
      tick();
    end
    d_req = 0; d_wen = 0; i_req = 1; i_addr = 32'h400; #1;
    checks++; if (o_outstanding !== 2'd2 || o_i_gnt !== 1'b0 || o_s_req !== 1'b0) begin errors++; $display("FAIL full_block: out=%0d i_gnt=%b s_req=%b want 2/0/0", o_outstanding, o_i_gnt, o_s_req); end
    tick();
    s_recv = 1; d_ack = 1; #1;
    checks++; if (o_d_recv !== 1'b1 || o_s_ack !== 1'b1 || o_i_gnt !== 1'b0) begin errors++; $display("FAIL full_pop_cycle: d_recv=%b s_ack=%b i_gnt=%b want 1/1/0", o_d_recv, o_s_ack, o_i_gnt); end
    tick();
    s_recv = 0; #1;
    checks++; if (o_i_gnt !== 1'b1 || o_outstanding !== 2'd1) begin errors++; $display("FAIL full_unblock: i_gnt=%b out=%0d want 1/1", o_i_gnt, o_outstanding); end
    tick();
    i_req = 0; s_recv = 1; i_ack = 1; d_ack = 1; tick(); tick(); idle(); #1;
    checks++; if (o_outstanding !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", o_outstanding); end
  endtask

  task automatic test_stall();
    msel = 0; do_reset();
    d_req = 1; d_addr = 32'h500; s_gnt = 1; tick(); d_req = 0;
    for (int k = 0; k < 4; k++) begin
      i_req = (k == 0); i_addr = 32'h600; s_recv = 1; d_ack = (k == 3); s_rdata = 32'hBEE0 + k; #1;
      checks++; if (o_d_recv !== 1'b1 || o_i_recv !== 1'b0 || o_s_ack !== (k == 3)) begin errors++; $display("FAIL stall[%0d]: d_recv=%b i_recv=%b s_ack=%b", k, o_d_recv, o_i_recv, o_s_ack); end
      if (k == 0) begin checks++; if (o_i_gnt !== 1'b1) begin errors++; $display("FAIL stall_accept: i_gnt=%b want 1", o_i_gnt); end end
      if (k == 3) begin checks++; if (o_outstanding !== 2'd2) begin errors++; $display("FAIL stall_out: got %0d want 2", o_outstanding); end end
      tick();
    end
    i_req = 0; d_ack = 0; i_ack = 1; s_recv = 1; s_error = 1; s_rdata = 32'h55; #1;
    checks++; if (o_i_recv !== 1'b1 || o_i_error !== 1'b1 || o_i_rdata !== 32'h55 || o_d_recv !== 1'b0 || o_d_error !== 1'b0) begin errors++; $display("FAIL stall_ierr: i_recv=%b i_err=%b rdata=%h d_recv=%b d_err=%b", o_i_recv, o_i_error, o_i_rdata, o_d_recv, o_d_error); end
    tick(); idle(); #1;
    checks++; if (o_outstanding !== 2'd0) begin errors++; $display("FAIL stall_drain: got %0d want 0", o_outstanding); end
  endtask

  task automatic test_orphan_reset();
    msel = 0; do_reset();
    s_recv = 1; #1;
    checks++; if (o_s_ack !== 1'b1 || o_i_recv !== 1'b0 || o_d_recv !== 1'b0) begin errors++; $display("FAIL orphan_drain: s_ack=%b i_recv=%b d_recv=%b want 1/0/0", o_s_ack, o_i_recv, o_d_recv); end
    tick(); s_recv = 0; #1;
    checks++; if (o_err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %b want 1", o_err_orphan); end
    i_req = 1; s_gnt = 1; tick(); i_req = 0; #1;
    checks++; if (o_outstanding !== 2'd1 || o_err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_hold: out=%0d orphan=%b want 1/1", o_outstanding, o_err_orphan); end
    do_reset(); #1;
    checks++; if (o_outstanding !== 2'd0 || o_err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_reset: out=%0d orphan=%b want 0/0", o_outstanding, o_err_orphan); end
    i_req = 1; d_req = 1; s_gnt = 1; #1;
    checks++; if (o_i_gnt !== 1'b1 || o_d_gnt !== 1'b0) begin errors++; $display("FAIL orphan_first_rr: i_gnt=%b d_gnt=%b want 1/0", o_i_gnt, o_d_gnt); end
    tick(); idle();
  endtask

  task automatic test_random(input bit sel);
    bit gi, gd;
    msel = sel; do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!i_req && $urandom_range(2) == 0) begin i_req = 1; i_wen = 1'($urandom); i_strb = 4'($urandom); i_wdata = $urandom; i_addr = $urandom; end
      if (!d_req && $urandom_range(2) == 0) begin d_req = 1; d_wen = 1'($urandom); d_strb = 4'($urandom); d_wdata = $urandom; d_addr = $urandom; end
      s_gnt = ($urandom_range(3) != 0); s_recv = 1'($urandom); i_ack = ($urandom_range(3) != 0); d_ack = ($urandom_range(3) != 0);
      s_error = 1'($urandom); s_rdata = $urandom; #1;
      model_eval();
      checks++;
      if ({o_i_gnt, o_d_gnt, o_s_req, o_i_recv, o_d_recv, o_s_ack, o_i_error, o_d_error, o_err_orphan, o_s_wen, o_s_strb, o_outstanding} !==
          {e_i_gnt, e_d_gnt, e_s_req, e_i_recv, e_d_recv, e_s_ack, e_i_error, e_d_error, morph, e_s_wen, e_s_strb, e_out}) begin
        errors++; $display("FAIL rand_ctrl inst=%0d cyc=%0d: got %b want %b", sel, n,
          {o_i_gnt, o_d_gnt, o_s_req, o_i_recv, o_d_recv, o_s_ack, o_i_error, o_d_error, o_err_orphan, o_s_wen, o_s_strb, o_outstanding},
          {e_i_gnt, e_d_gnt, e_s_req, e_i_recv, e_d_recv, e_s_ack, e_i_error, e_d_error, morph, e_s_wen, e_s_strb, e_out});
      end
      checks++;
      if ({o_i_rdata, o_d_rdata, o_s_wdata, o_s_addr} !== {e_i_rdata, e_d_rdata, e_s_wdata, e_s_addr}) begin
        errors++; $display("FAIL rand_data inst=%0d cyc=%0d: got %h want %h", sel, n,
          {o_i_rdata, o_d_rdata, o_s_wdata, o_s_addr}, {e_i_rdata, e_d_rdata, e_s_wdata, e_s_addr});
      end
      gi = e_i_gnt; gd = e_d_gnt;
      tick();
      if (gi) i_req = 0;
      if (gd) d_req = 0;
    end
    idle();
  endtask

  initial begin
    msel = 0; g_reset = 1; idle();
    @(negedge g_clk);
    test_reset();
    test_single_port();
    test_rr_contention();
    test_priority();
    test_full();
    test_stall();
    test_orphan_reset();
    test_random(1'b0);
    test_random(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
